// File: rtl/memory_responder.sv
// memory_responder: responder side of the CPU memory interface.
// Serves single-word read/write requests from block RAM or a small I/O page
// (switches, LEDs, hex display) and completes each one with a one-cycle ready.
//
// Handshake: request is sampled only in IDLE, and address/write_data/
// write_enable are captured in that same cycle. Every accepted request ends
// with exactly one ready pulse; read_data and fault are valid while ready=1.
// fault is 0 whenever ready is 0. read_data holds until the next completion.
module memory_responder #(
  parameter int          DATA_WIDTH        = 16,
  parameter int          RAM_ADDRESS_WIDTH = 10,
  parameter logic [15:0] IO_BASE           = 16'hFF00,
  parameter int          SWITCH_WIDTH      = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         request,
  input  logic                         write_enable,
  input  logic [15:0]                  address,
  input  logic [DATA_WIDTH-1:0]        write_data,
  output logic                         ready,
  output logic [DATA_WIDTH-1:0]        read_data,
  output logic                         fault,
  output logic [RAM_ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]        ram_write_data,
  output logic                         ram_write_enable,
  input  logic [DATA_WIDTH-1:0]        ram_read_data,
  input  logic [SWITCH_WIDTH-1:0]      switches,
  output logic [SWITCH_WIDTH-1:0]      leds,
  output logic [DATA_WIDTH-1:0]        display
);

  localparam logic [15:0] SWITCH_ADDRESS  = IO_BASE;
  localparam logic [15:0] LED_ADDRESS     = IO_BASE + 16'd1;
  localparam logic [15:0] DISPLAY_ADDRESS = IO_BASE + 16'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0]             address_q;
  logic [DATA_WIDTH-1:0]   write_data_q;
  logic                    write_enable_q;
  logic                    fault_q;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic [SWITCH_WIDTH-1:0] leds_q;
  logic [DATA_WIDTH-1:0]   display_q;
  logic [SWITCH_WIDTH-1:0] switch_meta;
  logic [SWITCH_WIDTH-1:0] switch_sync;

  logic is_ram;
  logic is_switch;
  logic is_led;
  logic is_display;
  logic is_unmapped;

  // RAM is selected only when every address bit above the RAM index is zero,
  // so high addresses never alias onto RAM words.
  assign is_ram      = ((address_q >> RAM_ADDRESS_WIDTH) == 16'd0);
  assign is_switch   = (address_q == SWITCH_ADDRESS);
  assign is_led      = (address_q == LED_ADDRESS);
  assign is_display  = (address_q == DISPLAY_ADDRESS);
  assign is_unmapped = !(is_ram || is_switch || is_led || is_display);

  // RAM port is driven from the latched request in every state; the write
  // strobe is gated by reset so a reset during ACCESS cancels the store.
  assign ram_address      = address_q[RAM_ADDRESS_WIDTH-1:0];
  assign ram_write_data   = write_data_q;
  assign ram_write_enable = reset && (state == ACCESS) && write_enable_q && is_ram;

  assign read_data = read_data_q;
  assign leds      = leds_q;
  assign display   = display_q;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; RAM reads take the extra WAIT cycle.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE:    if (request) state_next = ACCESS;
      ACCESS:  state_next = (is_ram && !write_enable_q) ? WAIT : RESPOND;
      WAIT:    state_next = RESPOND;
      RESPOND: begin
        ready      = 1'b1;
        fault      = fault_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, I/O register updates and read-data loading.
  always_ff @(posedge clock) begin
    if (!reset) begin
      address_q      <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      fault_q        <= 1'b0;
      read_data_q    <= '0;
      leds_q         <= '0;
      display_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            address_q      <= address;
            write_data_q   <= write_data;
            write_enable_q <= write_enable;
          end
        end
        ACCESS: begin
          fault_q <= is_unmapped;
          if (is_unmapped) begin
            read_data_q <= '0;
          end else if (write_enable_q) begin
            // Writes to the switch word are dropped without a fault.
            if (is_led)     leds_q    <= write_data_q[SWITCH_WIDTH-1:0];
            if (is_display) display_q <= write_data_q;
          end else if (is_switch) begin
            read_data_q <= {{(DATA_WIDTH-SWITCH_WIDTH){1'b0}}, switch_sync};
          end else if (is_led) begin
            read_data_q <= {{(DATA_WIDTH-SWITCH_WIDTH){1'b0}}, leds_q};
          end else if (is_display) begin
            read_data_q <= display_q;
          end
        end
        WAIT:    read_data_q <= ram_read_data;
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      switch_meta <= switches;
      switch_sync <= switch_meta;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a behavioural block RAM model.
module tb_memory_responder;

  logic        clock;
  logic        reset;
  logic        request;
  logic        write_enable;
  logic [15:0] address;
  logic [15:0] write_data;
  logic        ready;
  logic [15:0] read_data;
  logic        fault;
  logic [9:0]  ram_address;
  logic [15:0] ram_write_data;
  logic        ram_write_enable;
  logic [15:0] ram_read_data;
  logic [9:0]  switches;
  logic [9:0]  leds;
  logic [15:0] display;

  int checks   = 0;
  int failures = 0;
  int we_total = 0;
  int fault_glitch = 0;

  logic [15:0] mem [0:1023];

  memory_responder dut (
    .clock            (clock),
    .reset            (reset),
    .request          (request),
    .write_enable     (write_enable),
    .address          (address),
    .write_data       (write_data),
    .ready            (ready),
    .read_data        (read_data),
    .fault            (fault),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .ram_read_data    (ram_read_data),
    .switches         (switches),
    .leds             (leds),
    .display          (display)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM model: synchronous write, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_write_enable === 1'b1) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  // Monitors for write strobes and fault outside a ready pulse.
  always @(negedge clock) begin
    if (ram_write_enable === 1'b1) we_total++;
    if (fault === 1'b1 && ready !== 1'b1) fault_glitch++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the fields.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] data);
    request      = 1'b1;
    write_enable = we;
    address      = addr;
    write_data   = data;
    tick();
    request      = 1'b0;
    write_enable = ~we;
    address      = ~addr;
    write_data   = ~data;
  endtask

  // Wait (bounded) for ready; report latency, data, fault, and write strobes.
  task automatic wait_ready(output int lat, output logic [15:0] rd, output logic flt,
                            output logic [7:0] we_seen, output logic [9:0] we_addr);
    lat = 0;
    rd = 'x;
    flt = 1'bx;
    we_seen = '0;
    we_addr = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (ram_write_enable === 1'b1) begin
        we_seen[n-1] = 1'b1;
        we_addr = ram_address;
      end
      if (ready === 1'b1) begin
        lat = n;
        rd  = read_data;
        flt = fault;
      end
      tick();
      if (lat != 0) break;
    end
    if (lat != 0) begin
      @(negedge clock);
      check("ready_width", {31'd0, ready}, 32'd0);
      tick();
    end
  endtask

  int          lat;
  logic [15:0] rd;
  logic        flt;
  logic [7:0]  we_seen;
  logic [9:0]  we_addr;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[9] = 16'h1357;
    reset = 1'b0;
    request = 1'b0;
    write_enable = 1'b0;
    address = 16'h0000;
    write_data = 16'h0000;
    switches = 10'h000;

    // Reset for two cycles.
    tick();
    tick();
    @(negedge clock);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_leds", {22'd0, leds}, 32'd0);
    check("rst_display", {16'd0, display}, 32'd0);
    check("rst_read_data", {16'd0, read_data}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_we", we_total, 32'd0);

    // RAM write BEEF to 5.
    issue(1'b1, 16'h0005, 16'hBEEF);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("wr5_lat", lat, 32'd2);
    check("wr5_fault", {31'd0, flt}, 32'd0);
    check("wr5_we_cycle", {24'd0, we_seen}, 32'h01);
    check("wr5_we_addr", {22'd0, we_addr}, 32'd5);
    check("wr5_mem", {16'd0, mem[5]}, 32'h0000BEEF);

    // RAM read 5.
    issue(1'b0, 16'h0005, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("rd5_lat", lat, 32'd3);
    check("rd5_data", {16'd0, rd}, 32'h0000BEEF);
    check("rd5_fault", {31'd0, flt}, 32'd0);
    check("rd5_no_we", {24'd0, we_seen}, 32'h00);

    // Display and LED writes.
    issue(1'b1, 16'hFF02, 16'h1234);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("disp_lat", lat, 32'd2);
    check("disp_val", {16'd0, display}, 32'h00001234);
    check("disp_no_we", {24'd0, we_seen}, 32'h00);
    issue(1'b1, 16'hFF01, 16'hFFFF);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("led_lat", lat, 32'd2);
    check("led_val", {22'd0, leds}, 32'h3FF);

    // Switch read through the synchronizer.
    switches = 10'h155;
    tick();
    tick();
    tick();
    issue(1'b0, 16'hFF00, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("sw_lat", lat, 32'd2);
    check("sw_data", {16'd0, rd}, 32'h00000155);
    issue(1'b0, 16'hFF01, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("led_rd", {16'd0, rd}, 32'h000003FF);
    issue(1'b0, 16'hFF02, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("disp_rd", {16'd0, rd}, 32'h00001234);

    // Unmapped accesses.
    issue(1'b0, 16'h8000, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("um_rd_lat", lat, 32'd2);
    check("um_rd_fault", {31'd0, flt}, 32'd1);
    check("um_rd_data", {16'd0, rd}, 32'd0);
    issue(1'b1, 16'hFF07, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("um_wr_fault", {31'd0, flt}, 32'd1);
    check("um_wr_leds", {22'd0, leds}, 32'h3FF);
    check("um_wr_disp", {16'd0, display}, 32'h00001234);
    check("um_wr_no_we", {24'd0, we_seen}, 32'h00);
    issue(1'b1, 16'hFF00, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("sw_wr_lat", lat, 32'd2);
    check("sw_wr_fault", {31'd0, flt}, 32'd0);

    // Continuous request: reads of 5, fields scrambled outside IDLE cycles.
    for (int k = 0; k < 16; k++) begin
      request = 1'b1;
      write_enable = 1'b0;
      address = (k % 4 == 0) ? 16'h0005 : 16'h0009;
      write_data = 16'h0F0F;
      @(negedge clock);
      check("hs_ready", {31'd0, ready}, (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k % 4 == 3) check("hs_data", {16'd0, read_data}, 32'h0000BEEF);
      tick();
    end
    request = 1'b0;
    tick();
    tick();

    // Reset during the ACCESS cycle of a RAM write.
    issue(1'b1, 16'h0009, 16'hAAAA);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_we", {31'd0, ram_write_enable}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mid_rst_no_ready", {31'd0, ready}, 32'd0);
      tick();
    end
    check("mid_rst_leds", {22'd0, leds}, 32'd0);
    check("mid_rst_disp", {16'd0, display}, 32'd0);
    issue(1'b0, 16'h0009, 16'h0000);
    wait_ready(lat, rd, flt, we_seen, we_addr);
    check("rd9_lat", lat, 32'd3);
    check("rd9_data", {16'd0, rd}, 32'h00001357);

    check("fault_only_with_ready", fault_glitch, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
